// File: rtl/dff_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// dff_share_arbiter_if
// Bundles the requester-facing and consumer-facing signals of the shared
// register arbiter.
//   req      requester -> arbiter  per-requester level request
//   d_bus    requester -> arbiter  packed data words, requester i in [i*WIDTH +: WIDTH]
//   gnt      arbiter -> requester  one-hot, one-cycle acknowledge
//   q        arbiter -> consumer   shared register contents
//   q_owner  arbiter -> consumer   index of the requester whose word is in q
//   q_valid  arbiter -> consumer   sticky "something was loaded since reset"
//   busy     arbiter -> consumer   hold window active, no load possible
// master: the environment (requesters + consumer); slave: the arbiter.
// ---------------------------------------------------------------------------
interface dff_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] d_bus;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic [OW-1:0]         q_owner;
    logic                  q_valid;
    logic                  busy;

    modport master (
        output req, d_bus,
        input  gnt, q, q_owner, q_valid, busy
    );

    modport slave (
        input  req, d_bus,
        output gnt, q, q_owner, q_valid, busy
    );
endinterface

// File: rtl/dff_share_arbiter.sv
// ---------------------------------------------------------------------------
// dff_share_arbiter
// Round-robin arbiter that shares one data register among NREQ requesters.
// One winner per load slot is captured into q, tagged in q_owner and
// acknowledged with a one-cycle gnt. After each load a hold window of HOLD
// cycles keeps q stable before the next load may happen.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears outputs, hold counter and pointer
//   bus    dff_share_arbiter_if.slave (req, d_bus in; gnt, q, q_owner,
//          q_valid, busy out -- all outputs registered)
// ---------------------------------------------------------------------------
module dff_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic              clk,
    input  logic              reset,
    dff_share_arbiter_if.slave bus
);
    localparam int OW = $clog2(NREQ);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [OW-1:0]    ptr_q;
    logic [NREQ-1:0]  gnt_q;
    logic [WIDTH-1:0] q_q;
    logic [OW-1:0]    owner_q;
    logic             valid_q;
    logic             busy_q;

    logic [NREQ-1:0]  elig_d;
    logic             found_d;
    logic [OW-1:0]    win_d;
    logic [OW-1:0]    ptr_d;
    logic [WIDTH-1:0] word_d;
    int               idx;

    // Rotating priority search: the requester just granted is masked out so
    // a still-high req cannot win twice in a row at back-to-back edges.
    always_comb begin
        elig_d  = bus.req & ~gnt_q;
        found_d = 1'b0;
        win_d   = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found_d && elig_d[idx]) begin
                found_d = 1'b1;
                win_d   = OW'(idx);
            end
        end
        word_d = bus.d_bus[int'(win_d)*WIDTH +: WIDTH];
        ptr_d  = (int'(win_d) == NREQ - 1) ? '0 : OW'(int'(win_d) + 1);
    end

    // ST_HOLD exactly covers cnt_q != 0, so the state doubles as the
    // "cnt == 0" load qualifier; busy_q is kept in step with the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            q_q     <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (state_q == ST_IDLE && found_d) begin
            q_q     <= word_d;
            owner_q <= win_d;
            gnt_q   <= NREQ'(1) << win_d;
            valid_q <= 1'b1;
            ptr_q   <= ptr_d;
            cnt_q   <= CW'(HOLD - 1);
            busy_q  <= (HOLD > 1) ? 1'b1 : 1'b0;
            state_q <= (HOLD > 1) ? ST_HOLD : ST_IDLE;
        end else begin
            gnt_q <= '0;
            if (state_q == ST_HOLD) begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            end
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.q       = q_q;
    assign bus.q_owner = owner_q;
    assign bus.q_valid = valid_q;
    assign bus.busy    = busy_q;
endmodule
